// File: rtl/minmax_pkg.sv
// Shared types and default sizing for the min/max window tracker.
package minmax_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_WIN   = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/cmp_unit.sv
// Unsigned three-way magnitude comparator of a against b; purely combinational.
module cmp_unit #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             eq,
  output logic             gt,
  output logic             lt
);

  assign eq = (a == b);
  assign gt = (a > b);
  assign lt = (a < b);

endmodule

// File: rtl/minmax_tracker.sv
// Tracks running max/min of WIN unsigned samples per window, pulsing done at the end.
// Define MINMAX_EQCNT_EN to add the eq_cnt port counting ties with the current maximum.
module minmax_tracker
  import minmax_pkg::*;
#(
  parameter int  WIDTH = DEFAULT_WIDTH,
  parameter int  WIN   = DEFAULT_WIN,
  localparam int CNT_W = $clog2(WIN + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic [WIDTH-1:0] max_out,
  output logic [WIDTH-1:0] min_out,
  output logic             busy,
  output logic             done
`ifdef MINMAX_EQCNT_EN
  ,
  output logic [CNT_W-1:0] eq_cnt
`endif
);

  state_t             state;
  state_t             state_next;
  logic [CNT_W-1:0]   cnt;
  logic               have_sample;
  logic               accept;
  logic               last_sample;
  logic               max_eq, max_gt, max_lt;
  logic               min_eq, min_gt, min_lt;

  cmp_unit #(.WIDTH(WIDTH)) u_cmp_max (
    .a  (in_data),
    .b  (max_out),
    .eq (max_eq),
    .gt (max_gt),
    .lt (max_lt)
  );

  cmp_unit #(.WIDTH(WIDTH)) u_cmp_min (
    .a  (in_data),
    .b  (min_out),
    .eq (min_eq),
    .gt (min_gt),
    .lt (min_lt)
  );

  // Only half of each comparator's result is needed for the update rules.
  logic unused_cmp;
  assign unused_cmp = &{1'b0, max_eq, max_lt, min_eq, min_gt};

  assign accept      = in_valid & in_ready;
  assign last_sample = accept && (cnt == CNT_W'(WIN - 1));

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: defaulting state_next before the case keeps this block free of inferred latches.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last_sample) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      RUN: begin
        in_ready = 1'b1;
        busy     = 1'b1;
      end
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      have_sample <= 1'b0;
    end else if (state == IDLE && start) begin
      cnt         <= '0;
      have_sample <= 1'b0;
    end else if (accept) begin
      cnt         <= cnt + CNT_W'(1);
      have_sample <= 1'b1;
    end
  end

  // Results persist through IDLE; only the first sample of a new window overwrites them.
  always_ff @(posedge clk) begin
    if (rst) begin
      max_out <= '0;
      min_out <= '0;
    end else if (accept) begin
      if (!have_sample) begin
        max_out <= in_data;
        min_out <= in_data;
      end else begin
        if (max_gt) max_out <= in_data;
        if (min_lt) min_out <= in_data;
      end
    end
  end

`ifdef MINMAX_EQCNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      eq_cnt <= '0;
    end else if (accept) begin
      if (!have_sample || max_gt) begin
        eq_cnt <= CNT_W'(1);
      end else if (max_eq) begin
        eq_cnt <= eq_cnt + CNT_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_minmax_tracker.sv
// Self-checking bench for minmax_tracker (WIDTH=8, WIN=4); window results go through a scoreboard queue.
module tb_minmax_tracker;

  localparam int WIDTH = 8;
  localparam int WIN   = 4;
  localparam int CNT_W = $clog2(WIN + 1);

  logic             clk;
  logic             rst;
  logic             start;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic [WIDTH-1:0] max_out;
  logic [WIDTH-1:0] min_out;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] eq_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [WIDTH-1:0] s [WIN];
    bit               gaps;
    logic [WIDTH-1:0] emax;
    logic [WIDTH-1:0] emin;
    int               eeq;
  } vec_t;

  typedef struct {
    logic [WIDTH-1:0] emax;
    logic [WIDTH-1:0] emin;
    int               eeq;
  } exp_t;

  exp_t exp_q[$];
  vec_t vecs[5];

  minmax_tracker #(.WIDTH(WIDTH), .WIN(WIN)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .max_out  (max_out),
    .min_out  (min_out),
    .busy     (busy),
    .done     (done)
`ifdef MINMAX_EQCNT_EN
    ,
    .eq_cnt   (eq_cnt)
`endif
  );

`ifndef MINMAX_EQCNT_EN
  assign eq_cnt = '0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every done pulse must match the oldest pending window result.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected no pending window at %0t", $time);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("sb_max_out", 32'(max_out), 32'(e.emax));
        check("sb_min_out", 32'(min_out), 32'(e.emin));
`ifdef MINMAX_EQCNT_EN
        check("sb_eq_cnt", 32'(eq_cnt), 32'(e.eeq));
`endif
      end
    end
  end

  function automatic vec_t make_vec(input logic [WIDTH-1:0] a, b, c, d, input bit gaps,
                                    input logic [WIDTH-1:0] emax, emin, input int eeq);
    vec_t v;
    v.s[0] = a; v.s[1] = b; v.s[2] = c; v.s[3] = d;
    v.gaps = gaps; v.emax = emax; v.emin = emin; v.eeq = eeq;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_window();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("run_busy", 32'(busy), 32'd1);
  endtask

  // Drives one sample; the window's last sample must land the FSM in DONE.
  task automatic send_sample(input logic [WIDTH-1:0] data, input bit is_last, input bit gap_after);
    check("in_ready_run", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_data  = data;
    tick();
    in_valid = 1'b0;
    in_data  = 8'hFF;
    if (is_last) begin
      check("done_pulse", 32'(done), 32'd1);
      check("done_in_ready", 32'(in_ready), 32'd0);
      check("done_busy", 32'(busy), 32'd1);
    end else begin
      check("no_early_done", 32'(done), 32'd0);
      if (gap_after) begin
        in_data = 8'h00;
        tick();
        in_data = 8'hFF;
        check("gap_no_done", 32'(done), 32'd0);
      end
    end
  endtask

  task automatic finish_window(input logic [WIDTH-1:0] emax, emin);
    tick();
    check("done_one_cycle", 32'(done), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_in_ready", 32'(in_ready), 32'd0);
    check("hold_max", 32'(max_out), 32'(emax));
    check("hold_min", 32'(min_out), 32'(emin));
  endtask

  task automatic run_window(input vec_t v);
    exp_q.push_back('{emax: v.emax, emin: v.emin, eeq: v.eeq});
    start_window();
    for (int i = 0; i < WIN; i++) begin
      send_sample(v.s[i], i == WIN - 1, v.gaps);
    end
    finish_window(v.emax, v.emin);
  endtask

  initial begin
    vecs[0] = make_vec(8'h1C, 8'h7C, 8'h14, 8'h9C, 1'b0, 8'h9C, 8'h14, 1);
    vecs[1] = make_vec(8'h1C, 8'h1C, 8'h1C, 8'h1C, 1'b0, 8'h1C, 8'h1C, 4);
    vecs[2] = make_vec(8'hDC, 8'h04, 8'hD4, 8'h00, 1'b1, 8'hDC, 8'h00, 1);
    vecs[3] = make_vec(8'h00, 8'hFF, 8'hFF, 8'h80, 1'b0, 8'hFF, 8'h00, 2);
    vecs[4] = make_vec(8'h80, 8'h80, 8'hFF, 8'h80, 1'b0, 8'hFF, 8'h80, 1);

    rst      = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    repeat (2) tick();
    check("rst_max", 32'(max_out), 32'd0);
    check("rst_min", 32'(min_out), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
`ifdef MINMAX_EQCNT_EN
    check("rst_eq_cnt", 32'(eq_cnt), 32'd0);
`endif
    rst = 1'b0;
    tick();
    check("idle_no_ready", 32'(in_ready), 32'd0);

    for (int i = 0; i < 5; i++) begin
      run_window(vecs[i]);
    end

    // Abort a window halfway with reset: no done, everything cleared.
    start_window();
    send_sample(8'h55, 1'b0, 1'b0);
    send_sample(8'h66, 1'b0, 1'b0);
    check("partial_max", 32'(max_out), 32'h66);
    check("partial_min", 32'(min_out), 32'h55);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_in_ready", 32'(in_ready), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_max", 32'(max_out), 32'd0);
    check("abort_min", 32'(min_out), 32'd0);
`ifdef MINMAX_EQCNT_EN
    check("abort_eq_cnt", 32'(eq_cnt), 32'd0);
`endif
    repeat (3) tick();
    check("abort_still_idle", 32'(busy), 32'd0);
    run_window(vecs[0]);

    // start held high across a whole window and into the next one.
    exp_q.push_back('{emax: 8'h40, emin: 8'h10, eeq: 1});
    start = 1'b1;
    tick();
    check("held_run_busy", 32'(busy), 32'd1);
    check("held_hold_max", 32'(max_out), 32'h9C);
    send_sample(8'h10, 1'b0, 1'b0);
    send_sample(8'h20, 1'b0, 1'b0);
    send_sample(8'h30, 1'b0, 1'b0);
    send_sample(8'h40, 1'b1, 1'b0);
    tick();
    check("held_back_idle", 32'(busy), 32'd0);
    check("held_idle_ready", 32'(in_ready), 32'd0);
    tick();
    start = 1'b0;
    check("held_restart_busy", 32'(busy), 32'd1);
    check("held_restart_ready", 32'(in_ready), 32'd1);
    check("held_keep_max", 32'(max_out), 32'h40);
    check("held_keep_min", 32'(min_out), 32'h10);
    exp_q.push_back('{emax: 8'h05, emin: 8'h05, eeq: 4});
    for (int i = 0; i < WIN; i++) begin
      send_sample(8'h05, i == WIN - 1, 1'b0);
    end
    finish_window(8'h05, 8'h05);

    repeat (2) tick();
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/minmax_tracker.md
MINMAX_TRACKER -- requirements
Module: minmax_tracker

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand width in bits.
REQ-002 SHALL have parameter WIN, default 16, number of samples per window (legal range 2..255).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port start  input  1  begins a new window when the block is idle.
REQ-006 SHALL have port in_valid  input  1  in_data is valid.
REQ-007 SHALL have port in_data  input  WIDTH  unsigned sample.
REQ-008 SHALL have port in_ready  output  1  block accepts a sample this cycle.
REQ-009 SHALL have port max_out  output  WIDTH  running and final maximum.
REQ-010 SHALL have port min_out  output  WIDTH  running and final minimum.
REQ-011 SHALL have port busy  output  1  high while a window is in progress.
REQ-012 SHALL have port done  output  1  one-cycle pulse at end of window.
REQ-013 SHALL have port eq_cnt  output  $clog2(WIN+1)  count of max ties; present only under MINMAX_EQCNT_EN.

Function
REQ-014 SHALL implement FSM states IDLE, RUN and DONE.
REQ-015 In IDLE, start=1 SHALL move the FSM to RUN next cycle and clear the sample counter and first-sample flag; otherwise the FSM SHALL hold.
REQ-016 in_ready SHALL equal 1 only in RUN; a sample is accepted when in_valid and in_ready are both high.
REQ-017 On the first accepted sample of a window, the block SHALL load both max_out and min_out with in_data.
REQ-018 On each later accepted sample, the block SHALL load max_out when in_data > max_out and load min_out when in_data < min_out (unsigned); on equality both SHALL hold.
REQ-019 max_out and min_out SHALL be registered and SHALL reflect an accepted sample on the following cycle.
REQ-020 The block SHALL count accepted samples; acceptance of the WIN-th sample SHALL move the FSM to DONE next cycle.
REQ-021 In DONE, done SHALL be 1 for exactly one cycle, in_ready SHALL be 0, and the FSM SHALL then return to IDLE.
REQ-022 busy SHALL be 1 in RUN and DONE, and 0 in IDLE.
REQ-023 start SHALL be ignored in RUN and DONE; a start in the cycle the FSM returns to IDLE SHALL be honoured.
REQ-024 max_out and min_out SHALL hold their final values through IDLE until the first accepted sample of the next window.
REQ-025 A cycle with in_valid=0 in RUN SHALL change no state.

Reset
REQ-026 With rst=1 at a clock edge, the FSM SHALL go to IDLE and max_out, min_out, done, busy, in_ready, the counter and eq_cnt SHALL all go to 0.
REQ-027 Reset SHALL take priority over start and sample acceptance, including in the middle of a window; the partial window is discarded with no done pulse.

Configuration
REQ-028 With macro MINMAX_EQCNT_EN defined, the eq_cnt port and its logic SHALL exist.
REQ-029 With MINMAX_EQCNT_EN, eq_cnt SHALL behave as follows: set to 1 on the first accepted sample and on each new maximum; incremented on each accepted sample equal to max_out; otherwise held.
REQ-030 Without MINMAX_EQCNT_EN, the eq_cnt port and its logic SHALL be absent; all other behaviour SHALL be unchanged.

Structure
REQ-031 A shared package minmax_pkg SHALL hold the FSM state enum type and the default WIDTH and WIN constants.
REQ-032 Comparison SHALL be done by two instances of one sub-module, cmp_unit, which is purely combinational with inputs a and b and outputs eq, gt and lt.
REQ-033 One cmp_unit instance SHALL compare in_data with max_out; the other SHALL compare in_data with min_out.

Verification (WIDTH=8, WIN=4)
REQ-034 Bench SHALL check: rst, then start, then samples 0x1C, 0x7C, 0x14, 0x9C -> max_out=0x9C, min_out=0x14, done pulses one cycle after the 4th acceptance.
REQ-035 Bench SHALL check: samples 0x1C x4 -> max_out=min_out=0x1C; eq_cnt=4 with MINMAX_EQCNT_EN.
REQ-036 Bench SHALL check: in_valid toggled 1-0-1-0 over samples 0xDC, 0x04, 0xD4, 0x00 -> gaps ignored, max_out=0xDC, min_out=0x00, done only after the 4th accepted sample.
REQ-037 Bench SHALL check: start, 2 samples accepted, then rst=1 for one cycle -> FSM IDLE, all outputs 0, no done pulse; a new window then completes normally.
REQ-038 Bench SHALL check: start asserted continuously through a window -> ignored during RUN/DONE, a new window begins on the IDLE cycle, and max_out/min_out hold until that window's first sample.
REQ-039 Bench SHALL check: samples 0x00, 0xFF, 0xFF, 0x80 -> max_out=0xFF, min_out=0x00; eq_cnt=2 with MINMAX_EQCNT_EN.
